// File: rtl/pipelined_memory.sv
// Parametrised single-port word memory with byte enables, a valid/ready request port,
// a READ_LATENCY-deep read response pipeline and an optional post-reset zero-fill.
module pipelined_memory #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 16,
    parameter int DEPTH          = 2**ADDR_WIDTH,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    init_done
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra address bit so DEPTH == 2**ADDR_WIDTH is representable without wrapping.
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LAST_L  = (ADDR_WIDTH+1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] ONE_L   = (ADDR_WIDTH+1)'(1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH:0]     clr_addr;
    logic                    clr_we;
    logic                    in_range;
    logic                    accept;
    logic                    wr_en;
    logic                    rd_en;
    logic [IW-1:0]           req_idx;
    logic [IW-1:0]           clr_idx;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    vld_p   [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   rdata_p [READ_LATENCY];
    logic                    err_p   [READ_LATENCY];

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_d,
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [NB-1:0]         be
    );
        logic [DATA_WIDTH-1:0] r;
        r = old_d;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) r[8*i +: 8] = wdata[8*i +: 8];
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
        else       state <= state_nxt;
    end

    // Ready is masked by reset so nothing is accepted while reset is held.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        clr_we    = 1'b0;
        case (state)
            CLEAR: begin
                clr_we = !reset;
                if (clr_addr == LAST_L) state_nxt = RUN;
            end
            RUN: req_ready = !reset;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)       clr_addr <= '0;
        else if (clr_we) clr_addr <= clr_addr + ONE_L;
    end

    always_ff @(posedge clk) begin
        if (reset)              init_done <= (CLEAR_ON_RESET == 0);
        else if (state == RUN)  init_done <= 1'b1;
    end

    assign in_range = ({1'b0, req_addr} < DEPTH_L);
    assign accept   = req_valid && req_ready;
    assign wr_en    = accept && req_write && in_range;
    assign rd_en    = accept && !req_write;
    assign req_idx  = req_addr[IW-1:0];
    assign clr_idx  = clr_addr[IW-1:0];

    always_ff @(posedge clk) begin
        if (clr_we)     mem[clr_idx] <= '0;
        else if (wr_en) mem[req_idx] <= merge_bytes(mem[req_idx], req_wdata, req_be);
    end

    // Stage 0: array sampled at the acceptance edge; later stages only delay.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) vld_p[i] <= 1'b0;
        end else begin
            vld_p[0] <= rd_en;
            for (int i = 1; i < READ_LATENCY; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rdata_p[0] <= in_range ? mem[req_idx] : '0;
            err_p[0]   <= !in_range;
        end
        for (int i = 1; i < READ_LATENCY; i++) begin
            rdata_p[i] <= rdata_p[i-1];
            err_p[i]   <= err_p[i-1];
        end
    end

    // Output stage: data and error forced to zero whenever no response is presented.
    assign rsp_valid = vld_p[READ_LATENCY-1];
    assign rsp_rdata = rsp_valid ? rdata_p[READ_LATENCY-1] : '0;
    assign rsp_err   = rsp_valid && err_p[READ_LATENCY-1];

endmodule

// File: tb/tb_pipelined_memory.sv
// Directed bench for pipelined_memory: three instances cover clear/byte-enable (u0),
// latency-3 and DEPTH=12 range checks (u1), and the no-clear configuration (u2).
module tb_pipelined_memory;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [3];
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_write [3];
    logic [3:0]  req_addr  [3];
    logic [15:0] req_wdata [3];
    logic [1:0]  req_be    [3];
    logic        rsp_valid [3];
    logic [15:0] rsp_rdata [3];
    logic        rsp_err   [3];
    logic        init_done [3];

    int n_vec = 0;
    int n_bad = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        pipelined_memory #(
            .DATA_WIDTH     (16),
            .ADDR_WIDTH     (4),
            .DEPTH          (g == 1 ? 12 : 16),
            .READ_LATENCY   (g == 1 ? 3 : 1),
            .CLEAR_ON_RESET (g == 2 ? 0 : 1)
        ) u_dut (
            .clk       (clk),
            .reset     (rst[g]),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_write (req_write[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .req_be    (req_be[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g]),
            .init_done (init_done[g])
        );
    end

    function automatic int lat_of(input int d);
        return (d == 1) ? 3 : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_vec++;
        if (got !== exp_v) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp_v);
        end
    endtask

    task automatic hold_reset(input int d, input int n);
        rst[d]       = 1'b1;
        req_valid[d] = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic release_and_wait(input int d, input string tag, input int exp_len);
        int cnt;
        rst[d] = 1'b0;
        #1;
        cnt = 0;
        while (!req_ready[d] && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        chk(tag, 32'(cnt), 32'(exp_len));
    endtask

    task automatic do_write(input int d, input logic [3:0] a, input logic [15:0] data,
                            input logic [1:0] be);
        req_valid[d] = 1'b1;
        req_write[d] = 1'b1;
        req_addr[d]  = a;
        req_wdata[d] = data;
        req_be[d]    = be;
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_write[d] = 1'b0;
    endtask

    task automatic do_read(input int d, input logic [3:0] a, input logic [15:0] exp_d,
                           input logic exp_e, input string tag);
        int lat;
        req_valid[d] = 1'b1;
        req_write[d] = 1'b0;
        req_addr[d]  = a;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) req_valid[d] = 1'b0;
        end while (!rsp_valid[d] && lat < 10);
        chk({tag, "_lat"},  32'(lat),          32'(lat_of(d)));
        chk({tag, "_data"}, 32'(rsp_rdata[d]), 32'(exp_d));
        chk({tag, "_err"},  32'(rsp_err[d]),   32'(exp_e));
        @(negedge clk);
        chk({tag, "_pulse"}, {15'd0, rsp_valid[d], rsp_rdata[d]}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst[d]       = 1'b1;
            req_valid[d] = 1'b0;
            req_write[d] = 1'b0;
            req_addr[d]  = '0;
            req_wdata[d] = '0;
            req_be[d]    = '0;
        end
        @(negedge clk);

        // Instance 0: reset values, clear length, init_done timing, cleared contents
        hold_reset(0, 3);
        chk("rst_ready", 32'(req_ready[0]), 32'd0);
        chk("rst_valid", 32'(rsp_valid[0]), 32'd0);
        chk("rst_rdata", 32'(rsp_rdata[0]), 32'd0);
        chk("rst_err",   32'(rsp_err[0]),   32'd0);
        chk("rst_init",  32'(init_done[0]), 32'd0);
        release_and_wait(0, "clr_len", 16);
        chk("init_lo", 32'(init_done[0]), 32'd0);
        @(negedge clk);
        chk("init_hi", 32'(init_done[0]), 32'd1);
        for (int a = 0; a < 16; a++) do_read(0, 4'(a), 16'h0000, 1'b0, "clr_rd");

        // Byte enables, including the all-zero no-op and read-after-write ordering
        do_write(0, 4'd5, 16'hABCD, 2'b11);
        do_write(0, 4'd5, 16'h1200, 2'b10);
        do_read(0, 4'd5, 16'h12CD, 1'b0, "be_hi");
        do_write(0, 4'd5, 16'hFFFF, 2'b00);
        do_read(0, 4'd5, 16'h12CD, 1'b0, "be_none");
        do_write(0, 4'd5, 16'h34EE, 2'b01);
        do_read(0, 4'd5, 16'h12EE, 1'b0, "be_lo");

        // Reset during clear at clr_addr=7 restarts a full clear
        do_write(0, 4'd10, 16'h5A5A, 2'b11);
        do_read(0, 4'd10, 16'h5A5A, 1'b0, "pre_clr");
        hold_reset(0, 2);
        rst[0] = 1'b0;
        repeat (7) @(negedge clk);
        chk("midclr_rdy", 32'(req_ready[0]), 32'd0);
        hold_reset(0, 1);
        release_and_wait(0, "clr_restart", 16);
        do_read(0, 4'd10, 16'h0000, 1'b0, "clr_again");

        // Instance 1: DEPTH=12, READ_LATENCY=3
        hold_reset(1, 2);
        release_and_wait(1, "clr_len_b", 12);
        do_write(1, 4'd1, 16'h0011, 2'b11);
        do_write(1, 4'd2, 16'h0022, 2'b11);
        do_write(1, 4'd3, 16'h0033, 2'b11);
        for (int k = 0; k < 7; k++) begin
            if (k >= 3 && k <= 5) begin
                chk("l3_vld",  32'(rsp_valid[1]), 32'd1);
                chk("l3_data", 32'(rsp_rdata[1]), 32'(16'h0011 * (k - 2)));
            end else begin
                chk("l3_idle", 32'(rsp_valid[1]), 32'd0);
            end
            if (k < 3) begin
                req_valid[1] = 1'b1;
                req_write[1] = 1'b0;
                req_addr[1]  = 4'(k + 1);
            end else begin
                req_valid[1] = 1'b0;
            end
            @(negedge clk);
        end
        do_write(1, 4'd13, 16'hFFFF, 2'b11);
        do_read(1, 4'd13, 16'h0000, 1'b1, "oor13");
        do_read(1, 4'd11, 16'h0000, 1'b0, "in11");
        do_read(1, 4'd12, 16'h0000, 1'b1, "oor12");
        do_write(1, 4'd11, 16'h7777, 2'b11);
        do_read(1, 4'd11, 16'h7777, 1'b0, "in11_w");

        // Read in flight dropped by reset
        req_valid[1] = 1'b1;
        req_write[1] = 1'b0;
        req_addr[1]  = 4'd2;
        @(negedge clk);
        req_valid[1] = 1'b0;
        rst[1]       = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("drop_vld", 32'(rsp_valid[1]), 32'd0);
            @(negedge clk);
        end

        // Instance 2: CLEAR_ON_RESET=0
        hold_reset(2, 3);
        chk("c_rst_rdy",  32'(req_ready[2]), 32'd0);
        chk("c_rst_init", 32'(init_done[2]), 32'd1);
        rst[2] = 1'b0;
        #1;
        chk("c_rdy", 32'(req_ready[2]), 32'd1);
        do_write(2, 4'd9, 16'hBEEF, 2'b11);
        do_read(2, 4'd9, 16'hBEEF, 1'b0, "c_rd");
        chk("c_init", 32'(init_done[2]), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
